complex_inner_acc: RTL and testbench
====================================

// Module: complex_inner_acc
// PURPOSE
//  Accumulates a stream of complex products from the complex multiplier into one complex inner product.
//  Example: sum_k conj(q_k)*a_k, used for QR projection / R-matrix entries.
//  Sits directly downstream of the 2-stage-pipelined complex multiplier, which is free-running and
//  cannot stall; this block therefore never back-pressures its input.
//  Result is re-quantised, then offered downstream on a valid/ready handshake.
// PARAMETERS
//  I_WIDE  20  input word width; signed, 1 sign + I_INT integer + I_FRAC=I_WIDE-1-I_INT fraction bits
//  I_INT   2   input integer bits
//  O_WIDE  20  output word width; signed, O_FRAC=O_WIDE-1-O_INT fraction bits; O_FRAC<I_FRAC required
//  O_INT   4   output integer bits
//  N_MAX   16  max terms per inner product; ACC_W=I_WIDE+$clog2(N_MAX) guard-extended accumulator
// PORTS
//  i_clk        in   1          clock, rising edge
//  i_rst_n      in   1          asynchronous reset, active-low
//  i_valid      in   1          input term valid (aligned with multiplier output)
//  i_last       in   1          qualifies i_valid: final term of the current inner product
//  i_re         in   I_WIDE     term real part, signed
//  i_im         in   I_WIDE     term imaginary part, signed
//  i_err_clr    in   1          synchronous clear of o_err
//  i_ready      in   1          downstream accepts result
//  o_valid      out  1          result valid; held until i_ready
//  o_re         out  O_WIDE     rounded real sum
//  o_im         out  O_WIDE     rounded imaginary sum
//  o_count      out  $clog2(N_MAX+1)  number of terms in the presented result
//  o_err        out  2          sticky: [0] beat dropped while result pending, [1] N_MAX forced-last
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE; accumulators, o_re, o_im, o_count, o_valid and o_err all 0.
//  FSM IDLE -> ACC -> DONE:
//   IDLE: on i_valid load acc=sext(term), cnt=1; go to DONE if i_last, else ACC.
//   ACC:  on i_valid acc+=sext(term), cnt++; go to DONE on i_last or when cnt reaches N_MAX.
//         Reaching N_MAX without i_last sets o_err[1]; i_valid=0 holds state.
//   DONE: o_valid=1; o_re, o_im and o_count are stable.
//         i_ready=1: result consumed. Same-cycle i_valid starts the next sum (IDLE rules, zero bubble);
//         otherwise go to IDLE.
//         i_valid=1 with i_ready=0: beat discarded, o_err[0] set, result untouched.
//  Latency: last term sampled at edge t -> o_valid=1 after edge t (one register); back-to-back sums
//   run at full rate when i_ready=1.
//  Arithmetic: sext to ACC_W, two's-complement add, no overflow inside ACC_W.
//  Quantisation (per component): add 1 at bit (I_FRAC-O_FRAC-1) (round half up), arithmetic shift
//   right by I_FRAC-O_FRAC, then narrow to O_WIDE.
//  o_err: bits are OR-sticky; i_err_clr clears them, but a set event in the same cycle wins.
//  i_last without i_valid is ignored.
// CONFIGURATION
//  CPLX_ACC_SAT_EN defined: narrowing saturates to +(2^(O_WIDE-1)-1) / -2^(O_WIDE-1) per component.
//  Not defined: narrowing truncates MSBs (two's-complement wrap).
// STRUCTURE
//  Package qr_fixed_pkg: width localparams (I_FRAC, O_FRAC, ACC_W, SHIFT), FSM state enum,
//   o_err bit-index constants.
//  Sub-module cplx_round_narrow: one component's round + narrow (+sat under macro); instantiated
//   for re and im.
// TESTING (I_WIDE=20, I_INT=2, O_WIDE=20, O_INT=4, N_MAX=16; input 1.0=0x20000, output 1.0=0x08000)
//  4 terms, each 1.0+j0.5 (0x20000, 0x10000), i_ready=1 -> o_re=0x20000, o_im=0x10000, o_count=4,
//   o_valid one cycle after last.
//  Single term 0x00003 / 0x00001 with i_last -> o_re=0x00001 (0.75 rounds up), o_im=0x00000.
//  Back-to-back: 2-term sum then 3-term sum, i_ready=1, i_valid never drops -> two results,
//   no bubble, counts 2 then 3.
//  i_ready=0 in DONE for 3 cycles with i_valid=1 -> result unchanged, o_err=2'b01;
//   i_err_clr -> o_err=0.
//  16 terms of 1.5 (0x30000), no i_last -> DONE after 16th, o_err[1]=1.
//   Macro defined: o_re=0x7FFFF. Undefined: o_re=0xC0000.
//  Reset asserted mid-ACC after 2 terms -> immediate o_valid=0, outputs 0; next sum starts clean.

Source files
------------

// File: rtl/qr_fixed_pkg.sv
// Shared fixed-point widths, FSM state codes and o_err bit positions for the QR inner-product path.
// Defaults describe Q2.17 terms and Q4.15 results accumulated over up to 16 terms.
package qr_fixed_pkg;

  localparam int QF_I_WIDE = 20;
  localparam int QF_I_INT  = 2;
  localparam int QF_O_WIDE = 20;
  localparam int QF_O_INT  = 4;
  localparam int QF_N_MAX  = 16;

  localparam int I_FRAC = QF_I_WIDE - 1 - QF_I_INT;
  localparam int O_FRAC = QF_O_WIDE - 1 - QF_O_INT;
  localparam int ACC_W  = QF_I_WIDE + $clog2(QF_N_MAX);
  localparam int SHIFT  = I_FRAC - O_FRAC;

  typedef logic [1:0] acc_state_t;
  localparam acc_state_t ST_IDLE = 2'd0;
  localparam acc_state_t ST_ACC  = 2'd1;
  localparam acc_state_t ST_DONE = 2'd2;

  localparam int ERR_DROP  = 0;
  localparam int ERR_FORCE = 1;

endpackage

// File: rtl/cplx_round_narrow.sv
// Round-half-up, shift out SHIFT fraction bits and narrow one accumulator component to O_WIDE.
// CPLX_ACC_SAT_EN selects saturation on narrowing; otherwise the MSBs are dropped (wrap).
module cplx_round_narrow #(
  parameter int ACC_W  = 24,
  parameter int O_WIDE = 20,
  parameter int SHIFT  = 2
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [O_WIDE-1:0] q
);

  localparam int W = ACC_W + 1;

  // One extra bit so the rounding increment can never wrap the accumulator's top value.
  logic signed [W-1:0] ext;
  logic signed [W-1:0] rnd;
  logic signed [W-1:0] shr;

  assign ext = {acc[ACC_W-1], acc};
  assign rnd = ext + (W'(1) << (SHIFT - 1));
  assign shr = rnd >>> SHIFT;

`ifdef CPLX_ACC_SAT_EN
  logic ovf;
  // Representable iff every bit above the O_WIDE sign bit equals the sign.
  assign ovf = (shr[W-1:O_WIDE-1] != {(W-O_WIDE+1){shr[W-1]}});
  assign q   = !ovf       ? shr[O_WIDE-1:0] :
               shr[W-1]   ? {1'b1, {(O_WIDE-1){1'b0}}} :
                            {1'b0, {(O_WIDE-1){1'b1}}};
`else
  logic unused_hi;
  assign unused_hi = ^shr[W-1:O_WIDE];
  assign q         = shr[O_WIDE-1:0];
`endif

endmodule

// File: rtl/complex_inner_acc.sv
// Accumulates complex product terms into one inner product, re-quantises it and offers it on valid/ready.
// Never stalls its input; beats arriving while a result is held are dropped and flagged. CPLX_ACC_SAT_EN selects saturating output.
module complex_inner_acc
  import qr_fixed_pkg::*;
#(
  parameter int I_WIDE = QF_I_WIDE,
  parameter int I_INT  = QF_I_INT,
  parameter int O_WIDE = QF_O_WIDE,
  parameter int O_INT  = QF_O_INT,
  parameter int N_MAX  = QF_N_MAX
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic                       i_last,
  input  logic [I_WIDE-1:0]          i_re,
  input  logic [I_WIDE-1:0]          i_im,
  input  logic                       i_err_clr,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [O_WIDE-1:0]          o_re,
  output logic [O_WIDE-1:0]          o_im,
  output logic [$clog2(N_MAX+1)-1:0] o_count,
  output logic [1:0]                 o_err
);

  localparam int L_I_FRAC = I_WIDE - 1 - I_INT;
  localparam int L_O_FRAC = O_WIDE - 1 - O_INT;
  localparam int L_ACC_W  = I_WIDE + $clog2(N_MAX);
  localparam int L_SHIFT  = L_I_FRAC - L_O_FRAC;
  localparam int CNT_W    = $clog2(N_MAX + 1);

  acc_state_t         st;
  logic [L_ACC_W-1:0] acc_re, acc_im;
  logic [L_ACC_W-1:0] term_re, term_im;
  logic [CNT_W-1:0]   cnt, cnt_inc;
  logic [1:0]         err, err_set;
  logic               at_max;

  assign term_re = {{(L_ACC_W-I_WIDE){i_re[I_WIDE-1]}}, i_re};
  assign term_im = {{(L_ACC_W-I_WIDE){i_im[I_WIDE-1]}}, i_im};
  assign cnt_inc = cnt + CNT_W'(1);
  assign at_max  = (cnt_inc == CNT_W'(N_MAX));

  always_comb begin
    err_set = '0;
    if (st == ST_DONE && i_valid && !i_ready) err_set[ERR_DROP] = 1'b1;
    if (st == ST_ACC && i_valid && !i_last && at_max) err_set[ERR_FORCE] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st     <= ST_IDLE;
      acc_re <= '0;
      acc_im <= '0;
      cnt    <= '0;
      err    <= '0;
    end else begin
      // A set event in the same cycle as a clear must survive.
      err <= (i_err_clr ? 2'b00 : err) | err_set;
      case (st)
        ST_IDLE: if (i_valid) begin
          acc_re <= term_re;
          acc_im <= term_im;
          cnt    <= CNT_W'(1);
          st     <= i_last ? ST_DONE : ST_ACC;
        end
        ST_ACC: if (i_valid) begin
          acc_re <= acc_re + term_re;
          acc_im <= acc_im + term_im;
          cnt    <= cnt_inc;
          if (i_last || at_max) st <= ST_DONE;
        end
        ST_DONE: if (i_ready) begin
          // Consuming and starting the next sum in the same cycle keeps the stream bubble-free.
          if (i_valid) begin
            acc_re <= term_re;
            acc_im <= term_im;
            cnt    <= CNT_W'(1);
            st     <= i_last ? ST_DONE : ST_ACC;
          end else begin
            st <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  cplx_round_narrow #(.ACC_W(L_ACC_W), .O_WIDE(O_WIDE), .SHIFT(L_SHIFT)) u_rn_re (
    .acc (acc_re),
    .q   (o_re)
  );

  cplx_round_narrow #(.ACC_W(L_ACC_W), .O_WIDE(O_WIDE), .SHIFT(L_SHIFT)) u_rn_im (
    .acc (acc_im),
    .q   (o_im)
  );

  assign o_valid = (st == ST_DONE);
  assign o_count = cnt;
  assign o_err   = err;

endmodule

// File: tb/tb_complex_inner_acc.sv
// Self-checking bench for complex_inner_acc: directed scenarios plus randomized traffic against a term-list model.
// Expected saturation behaviour follows CPLX_ACC_SAT_EN, as for the design.
module tb_complex_inner_acc;

  localparam int IW = 20;
  localparam int OW = 20;
  localparam int NM = 16;
  localparam int SH = 2;
  localparam int CW = $clog2(NM + 1);

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_last = 1'b0;
  logic [IW-1:0] i_re = '0;
  logic [IW-1:0] i_im = '0;
  logic          i_err_clr = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_valid;
  logic [OW-1:0] o_re;
  logic [OW-1:0] o_im;
  logic [CW-1:0] o_count;
  logic [1:0]    o_err;

  int tests = 0;
  int failed = 0;

  // Model: running sum of the open inner product and the result being offered, if any.
  bit         pend;
  logic [19:0] pend_re, pend_im;
  int         pend_cnt;
  longint     sum_re, sum_im;
  int         n_terms;
  logic [1:0] m_err;

  complex_inner_acc #(.I_WIDE(IW), .I_INT(2), .O_WIDE(OW), .O_INT(4), .N_MAX(NM)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .i_last    (i_last),
    .i_re      (i_re),
    .i_im      (i_im),
    .i_err_clr (i_err_clr),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_re      (o_re),
    .o_im      (o_im),
    .o_count   (o_count),
    .o_err     (o_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [19:0] quant(input longint s);
    longint r;
    longint lim_hi;
    longint lim_lo;
    r = (s + (longint'(1) << (SH - 1))) >>> SH;
    lim_hi = (longint'(1) << (OW - 1)) - 1;
    lim_lo = -(longint'(1) << (OW - 1));
`ifdef CPLX_ACC_SAT_EN
    if (r > lim_hi) r = lim_hi;
    else if (r < lim_lo) r = lim_lo;
`else
    if (lim_hi < lim_lo) r = 0;
`endif
    return r[19:0];
  endfunction

  function automatic longint sx(input logic [19:0] v);
    return longint'($signed(v));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend = 0; pend_re = '0; pend_im = '0; pend_cnt = 0;
    sum_re = 0; sum_im = 0; n_terms = 0; m_err = 2'b00;
  endtask

  task automatic model_step(input logic v, input logic l, input logic [19:0] re,
                            input logic [19:0] im, input logic rdy, input logic clr);
    logic [1:0] set;
    set = 2'b00;
    if (pend && !rdy) begin
      if (v) set[0] = 1'b1;
    end else begin
      pend = 0;
      if (v) begin
        sum_re += sx(re);
        sum_im += sx(im);
        n_terms++;
        if (l || n_terms == NM) begin
          if (!l) set[1] = 1'b1;
          pend = 1;
          pend_re = quant(sum_re);
          pend_im = quant(sum_im);
          pend_cnt = n_terms;
          sum_re = 0; sum_im = 0; n_terms = 0;
        end
      end
    end
    m_err = (clr ? 2'b00 : m_err) | set;
  endtask

  task automatic check_all();
    chk("valid", 32'(o_valid), 32'(pend));
    chk("err", 32'(o_err), 32'(m_err));
    if (pend) begin
      chk("re", 32'(o_re), 32'(pend_re));
      chk("im", 32'(o_im), 32'(pend_im));
      chk("count", 32'(o_count), 32'(pend_cnt));
    end
  endtask

  task automatic cyc(input logic v, input logic l, input logic [19:0] re, input logic [19:0] im,
                     input logic rdy, input logic clr);
    i_valid = v; i_last = l; i_re = re; i_im = im; i_ready = rdy; i_err_clr = clr;
    @(posedge i_clk);
    model_step(v, l, re, im, rdy, clr);
    #1;
    check_all();
  endtask

  initial begin
    logic [19:0] rr, ri;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_re", 32'(o_re), 32'd0);
    chk("rst_im", 32'(o_im), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    i_rst_n = 1'b1;

    // Four terms of 1.0 + j0.5.
    for (int k = 0; k < 4; k++) cyc(1'b1, k == 3, 20'h20000, 20'h10000, 1'b1, 1'b0);
    chk("sum4_re", 32'(o_re), 32'h20000);
    chk("sum4_im", 32'(o_im), 32'h10000);
    chk("sum4_cnt", 32'(o_count), 32'd4);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Single term: 0.75 LSB rounds up, 0.25 LSB rounds down.
    cyc(1'b1, 1'b1, 20'h00003, 20'h00001, 1'b1, 1'b0);
    chk("rnd_re", 32'(o_re), 32'h00001);
    chk("rnd_im", 32'(o_im), 32'h00000);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Back-to-back 2-term and 3-term sums, no idle cycle.
    cyc(1'b1, 1'b0, 20'h04000, 20'hFC000, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 20'h04000, 20'hFC000, 1'b1, 1'b0);
    chk("b2b_cnt2", 32'(o_count), 32'd2);
    cyc(1'b1, 1'b0, 20'h08000, 20'h00004, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 20'h08000, 20'h00004, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 20'h08000, 20'h00004, 1'b1, 1'b0);
    chk("b2b_cnt3", 32'(o_count), 32'd3);
    chk("b2b_re3", 32'(o_re), 32'h06000);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Result held with ready low; arriving beats are dropped.
    cyc(1'b1, 1'b1, 20'h08000, 20'h00000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 20'h7FFFF, 20'h12345, 1'b0, 1'b0);
    chk("hold_re", 32'(o_re), 32'h02000);
    chk("hold_err", 32'(o_err), 32'h1);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("clr_err", 32'(o_err), 32'h0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Sixteen terms of 1.5 without i_last: forced completion.
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b0, 20'h30000, 20'h00000, 1'b1, 1'b0);
    chk("force_err1", 32'(o_err[1]), 32'd1);
    chk("force_cnt", 32'(o_count), 32'd16);
`ifdef CPLX_ACC_SAT_EN
    chk("force_re", 32'(o_re), 32'h7FFFF);
`else
    chk("force_re", 32'(o_re), 32'hC0000);
`endif
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);

    // Reset in the middle of an accumulation.
    cyc(1'b1, 1'b0, 20'h20000, 20'h20000, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 20'h20000, 20'h20000, 1'b1, 1'b0);
    #3 i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_re", 32'(o_re), 32'd0);
    chk("mid_rst_cnt", 32'(o_count), 32'd0);
    i_valid = 1'b0; i_last = 1'b0;
    #2 i_rst_n = 1'b1;
    cyc(1'b1, 1'b1, 20'h10000, 20'h00000, 1'b1, 1'b0);
    chk("post_rst_re", 32'(o_re), 32'h04000);
    chk("post_rst_cnt", 32'(o_count), 32'd1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      rr = 20'($urandom);
      ri = 20'($urandom);
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), rr, ri,
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
